wave_dac_gen: RTL
=================

// Module: wave_dac_gen
// PURPOSE
//  Parametrised DAC waveform generator; successor to the fixed square-wave source.
//  Produces the DAC sample clock DA_clk.
//  Also produces DA_digits, selectable as square (programmable period/duty), ramp, triangle or DC.
//  Levels and timing are runtime-programmable.
//  Sits between the control/config logic and the external parallel DAC.
// PARAMETERS
//  DATA_W      8      DAC sample width
//  CNT_W       32     width of period/duty/phase counters
//  DA_DIV      5      sys_clk cycles per DA_clk half-period (>=1)
//  DEF_PERIOD  100    reset period, in samples
//  DEF_DUTY    50     reset high-time, in samples
//  DEF_HI      8'hFF  reset high level
//  DEF_LO      8'h8F  reset low level
// PORTS
//  sys_clk    in   1       system clock
//  rst_n      in   1       asynchronous, active-low reset
//  en         in   1       run enable
//  cfg_load   in   1       1-cycle pulse: capture cfg_* into shadow registers
//  cfg_mode   in   2       0=square 1=ramp 2=triangle 3=DC
//  cfg_period in   CNT_W   samples per waveform cycle (square/ramp)
//  cfg_duty   in   CNT_W   samples at level_hi per cycle (square)
//  cfg_hi     in   DATA_W  high level
//  cfg_lo     in   DATA_W  low level
//  DA_clk     out  1       DAC sample clock, 50% duty, period 2*DA_DIV sys_clk
//  DA_digits  out  DATA_W  DAC code, registered
//  cyc_start  out  1       1-cycle pulse on the sample tick where phase==0
// BEHAVIOUR
//  Reset (async) values:
//   DA_clk=0, DA_digits=0, cyc_start=0, phase=0, dir=up.
//   Active and shadow config = DEF_* with mode=0; no pending load.
//  DA_clk:
//   - Divider count 0..DA_DIV-1; DA_clk toggles when count==DA_DIV-1.
//   - Runs regardless of en.
//  Sample tick (tick):
//   - Asserted in the sys_clk cycle where DA_clk toggles 1->0.
//   - DA_digits changes only on tick, so the code is stable at the DAC rising edge.
//  Config:
//   - cfg_load copies cfg_* to shadow and sets pending.
//   - Pending shadow is promoted to active on the first tick where phase wraps to 0,
//     or immediately (next cycle) if en=0.
//   - A cfg_load that coincides with promotion: the new values land in shadow and stay pending.
//  Phase:
//   - On tick with en=1: phase <= (phase >= P-1) ? 0 : phase+1.
//   - P = max(period,1); period=0 is treated as 1.
//  Output on tick (en=1), using the active config:
//   - square: DA_digits = (phase < duty) ? hi : lo.
//     duty=0 -> constant lo; duty>=P -> constant hi.
//   - ramp: DA_digits = min(lo+phase, hi), computed at DATA_W+1 bits and saturated at hi.
//     Restarts at lo on wrap.
//   - triangle: steps +1 from lo up to hi, then -1 back to lo, reversing at each end.
//     period is ignored; cyc_start fires on each arrival at lo.
//   - DC: constant hi.
//   - If hi<=lo in ramp/triangle -> constant lo.
//  cyc_start: 1 for one sys_clk on the tick that outputs phase 0 (or triangle lo).
//  en deassert:
//   - Phase reset to 0, dir reset to up.
//   - DA_digits <= active lo on the next tick; no cyc_start.
//   - On re-enable, the first tick outputs the phase-0 sample.
//  Mode change via promotion: phase and dir restart at 0/up.
//  Latency: DA_digits reflects phase n on the tick that advances to n (registered, 0 extra ticks).
// TESTING
//  1. Reset defaults, en=1, DA_DIV=5 -> DA_clk period 10 sys_clk.
//     Square: 50 ticks 0xFF, then 50 ticks 0x8F.
//     cyc_start every 1000 sys_clk.
//  2. cfg_load mid-cycle (period=4, duty=1, hi=0x80, lo=0x00)
//     -> old waveform finishes its cycle, then repeats 0x80,0x00,0x00,0x00.
//  3. Edge cases:
//     - duty=0 -> constant lo.
//     - duty=period=4 -> constant hi.
//     - period=0 -> phase stays 0, cyc_start on every tick.
//  4. ramp, lo=0x10, hi=0x13, period=6 -> 10,11,12,13,13,13 repeating.
//     triangle on the same levels -> 10,11,12,13,12,11,10,11...
//  5. en low mid-cycle: DA_clk keeps toggling, DA_digits -> lo.
//     Re-enable -> first sample is phase 0; cyc_start asserted.
//  6. rst_n pulsed low asynchronously mid-ramp -> all outputs 0 in the same cycle.
//     After release, the default square resumes and pending config is discarded.

Source files
------------

// File: rtl/wave_dac_gen_if.sv
// Configuration bus for wave_dac_gen.
// The control side drives it through the master modport; the generator samples it through the slave modport.
//   cfg_load   : 1-cycle pulse that captures the other cfg_* fields into the shadow registers
//   cfg_mode   : 0=square 1=ramp 2=triangle 3=DC
//   cfg_period : samples per waveform cycle (square/ramp/DC)
//   cfg_duty   : samples at the high level per cycle (square)
//   cfg_hi     : high level
//   cfg_lo     : low level
interface wave_dac_gen_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 32
);
  logic              cfg_load;
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_duty;
  logic [DATA_W-1:0] cfg_hi;
  logic [DATA_W-1:0] cfg_lo;

  modport master (output cfg_load, cfg_mode, cfg_period, cfg_duty, cfg_hi, cfg_lo);
  modport slave  (input  cfg_load, cfg_mode, cfg_period, cfg_duty, cfg_hi, cfg_lo);
endinterface

// File: rtl/wave_dac_gen.sv
// Parametrised DAC waveform generator.
// Produces the DAC sample clock and a registered sample code.
// The code is a square, ramp, triangle or DC waveform, with levels and timing programmable at runtime.
//   sys_clk   : system clock
//   rst_n     : asynchronous, active-low reset
//   en        : run enable
//   cfg       : configuration bus (slave side), captured into shadow registers on cfg_load
//   DA_clk    : DAC sample clock, 50% duty, period 2*DA_DIV sys_clk
//   DA_digits : DAC code, updated only on the DA_clk falling edge (sample tick)
//   cyc_start : 1-cycle pulse with the sample that starts a waveform cycle
module wave_dac_gen #(
  parameter int unsigned        DATA_W     = 8,
  parameter int unsigned        CNT_W      = 32,
  parameter int unsigned        DA_DIV     = 5,
  parameter logic [CNT_W-1:0]   DEF_PERIOD = CNT_W'(100),
  parameter logic [CNT_W-1:0]   DEF_DUTY   = CNT_W'(50),
  parameter logic [DATA_W-1:0]  DEF_HI     = DATA_W'('hFF),
  parameter logic [DATA_W-1:0]  DEF_LO     = DATA_W'('h8F)
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                en,
  wave_dac_gen_if.slave       cfg,
  output logic                DA_clk,
  output logic [DATA_W-1:0]   DA_digits,
  output logic                cyc_start
);

  localparam int unsigned     DIV_W    = (DA_DIV > 1) ? $clog2(DA_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DA_DIV - 1);

  localparam logic [1:0] MODE_SQUARE = 2'd0;
  localparam logic [1:0] MODE_RAMP   = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;
  localparam logic [1:0] MODE_DC     = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef struct packed {
    logic [1:0]        mode;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  duty;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{mode: MODE_SQUARE, period: DEF_PERIOD, duty: DEF_DUTY,
                               hi: DEF_HI, lo: DEF_LO};

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  cfg_t             act, shd, cfg_in, out_cfg;
  logic             pending;
  logic [CNT_W-1:0] phase, nxt_phase, p_last;
  logic [DATA_W-1:0] span;
  logic             dir, nxt_dir;
  logic             run;
  logic             wrap, promote;

  // Sample code for phase n under configuration c. Ramp and triangle both
  // use phase as the offset above lo; ramp saturates at hi.
  function automatic logic [DATA_W-1:0] sample(input cfg_t c, input logic [CNT_W-1:0] n);
    logic [DATA_W-1:0] s;
    s = c.lo;
    case (c.mode)
      MODE_SQUARE: s = (n < c.duty) ? c.hi : c.lo;
      MODE_RAMP, MODE_TRI: begin
        if (c.hi > c.lo)
          s = (n > CNT_W'(c.hi - c.lo)) ? c.hi : c.lo + DATA_W'(n);
      end
      default: s = c.hi;
    endcase
    return s;
  endfunction

  assign tick = (div_cnt == DIV_LAST) && DA_clk;

  always_comb begin
    cfg_in = '{mode: cfg.cfg_mode, period: cfg.cfg_period, duty: cfg.cfg_duty,
               hi: cfg.cfg_hi, lo: cfg.cfg_lo};
    p_last    = (act.period == '0) ? '0 : act.period - 1'b1;
    span      = (act.hi > act.lo) ? act.hi - act.lo : '0;
    nxt_phase = phase + 1'b1;
    nxt_dir   = dir;
    wrap      = 1'b0;
    if (!run) begin
      // First tick after reset or re-enable emits the phase-0 sample.
      nxt_phase = '0;
      nxt_dir   = DIR_UP;
      wrap      = 1'b1;
    end else if (act.mode == MODE_TRI) begin
      // Triangle ignores period; the cycle boundary is the arrival back at lo.
      if (span == '0) begin
        nxt_phase = '0;
        wrap      = 1'b1;
      end else if (dir == DIR_UP) begin
        if (nxt_phase == CNT_W'(span)) nxt_dir = DIR_DOWN;
      end else begin
        nxt_phase = phase - 1'b1;
        if (nxt_phase == '0) begin
          nxt_dir = DIR_UP;
          wrap    = 1'b1;
        end
      end
    end else if (phase >= p_last) begin
      nxt_phase = '0;
      wrap      = 1'b1;
    end
    promote = pending && wrap;
    if (promote) nxt_dir = DIR_UP;
    // The phase-0 sample that coincides with promotion already uses the new config.
    out_cfg = promote ? shd : act;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      DA_clk    <= 1'b0;
      DA_digits <= '0;
      cyc_start <= 1'b0;
      phase     <= '0;
      dir       <= DIR_UP;
      run       <= 1'b0;
      act       <= DEF_CFG;
      shd       <= DEF_CFG;
      pending   <= 1'b0;
    end else begin
      cyc_start <= 1'b0;

      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        DA_clk  <= ~DA_clk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (!en) begin
        phase <= '0;
        dir   <= DIR_UP;
        run   <= 1'b0;
        if (tick) DA_digits <= act.lo;
        if (pending) act <= shd;
      end else if (tick) begin
        phase     <= nxt_phase;
        dir       <= nxt_dir;
        run       <= 1'b1;
        DA_digits <= sample(out_cfg, nxt_phase);
        cyc_start <= wrap;
        if (promote) act <= shd;
      end

      // A load coinciding with promotion refills the shadow and stays pending.
      if (cfg.cfg_load) begin
        shd     <= cfg_in;
        pending <= 1'b1;
      end else if (pending && (!en || (tick && wrap))) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
